// File: rtl/one_unit_mean_accumulator_pkg.sv
// Shared constants and FSM encoding for the one-unit mean accumulator
// and the subtractor that consumes its mean matrix.
package one_unit_mean_accumulator_pkg;

    localparam int MEAN_DW     = 26;
    localparam int MEAN_N_LOG2 = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/one_unit_mean_accumulator_lane.sv
// One matrix element: wide signed accumulator plus the registered
// floor-shifted mean.
module one_unit_mean_lane
    import one_unit_mean_accumulator_pkg::*;
#(
    parameter int DW     = MEAN_DW,
    parameter int N_LOG2 = MEAN_N_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 add_en,
    input  logic                 load,
    input  logic signed [DW-1:0] sample,
    output logic signed [DW-1:0] mean
);

    localparam int AW = DW + N_LOG2;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] ext;

    assign ext = {{N_LOG2{sample[DW-1]}}, sample};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + ext;
        end
    end

    // Dropping the low N_LOG2 bits of a two's-complement sum floors it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mean <= '0;
        end else if (load) begin
            mean <= acc[N_LOG2 +: DW];
        end
    end

endmodule

// File: rtl/one_unit_mean_accumulator.sv
// Averages 2^N_LOG2 samples of a 4x4 signed matrix; the FSM and sample
// counter are shared by all sixteen lanes.
module one_unit_mean_accumulator
    import one_unit_mean_accumulator_pkg::*;
#(
    parameter int DW     = MEAN_DW,
    parameter int N_LOG2 = MEAN_N_LOG2
) (
    input  logic                 clk_mean,
    input  logic                 rst_mean,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] i_11, i_12, i_13, i_14,
    input  logic signed [DW-1:0] i_21, i_22, i_23, i_24,
    input  logic signed [DW-1:0] i_31, i_32, i_33, i_34,
    input  logic signed [DW-1:0] i_41, i_42, i_43, i_44,
    output logic signed [DW-1:0] m_11, m_12, m_13, m_14,
    output logic signed [DW-1:0] m_21, m_22, m_23, m_24,
    output logic signed [DW-1:0] m_31, m_32, m_33, m_34,
    output logic signed [DW-1:0] m_41, m_42, m_43, m_44,
    output logic                 busy,
    output logic                 done
);

    state_t            state;
    state_t            state_nx;
    logic [N_LOG2-1:0] cnt;
    logic              clr;
    logic              add_en;
    logic              load;

    logic signed [DW-1:0] in_v [16];
    logic signed [DW-1:0] m_v  [16];

    always_ff @(posedge clk_mean or posedge rst_mean) begin
        if (rst_mean) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = ACC;
            ACC: begin
                if (in_valid && (cnt == '1)) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ACC) || (state == DONE);
        clr    = (state == IDLE) && start;
        add_en = (state == ACC) && in_valid;
        load   = (state == DONE);
    end

    always_ff @(posedge clk_mean or posedge rst_mean) begin
        if (rst_mean) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= load;
            if (clr) begin
                cnt <= '0;
            end else if (add_en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign in_v[0]  = i_11;
    assign in_v[1]  = i_12;
    assign in_v[2]  = i_13;
    assign in_v[3]  = i_14;
    assign in_v[4]  = i_21;
    assign in_v[5]  = i_22;
    assign in_v[6]  = i_23;
    assign in_v[7]  = i_24;
    assign in_v[8]  = i_31;
    assign in_v[9]  = i_32;
    assign in_v[10] = i_33;
    assign in_v[11] = i_34;
    assign in_v[12] = i_41;
    assign in_v[13] = i_42;
    assign in_v[14] = i_43;
    assign in_v[15] = i_44;

    for (genvar g = 0; g < 16; g++) begin : g_lane
        one_unit_mean_lane #(
            .DW     (DW),
            .N_LOG2 (N_LOG2)
        ) u_lane (
            .clk    (clk_mean),
            .rst    (rst_mean),
            .clr    (clr),
            .add_en (add_en),
            .load   (load),
            .sample (in_v[g]),
            .mean   (m_v[g])
        );
    end

    assign m_11 = m_v[0];
    assign m_12 = m_v[1];
    assign m_13 = m_v[2];
    assign m_14 = m_v[3];
    assign m_21 = m_v[4];
    assign m_22 = m_v[5];
    assign m_23 = m_v[6];
    assign m_24 = m_v[7];
    assign m_31 = m_v[8];
    assign m_32 = m_v[9];
    assign m_33 = m_v[10];
    assign m_34 = m_v[11];
    assign m_41 = m_v[12];
    assign m_42 = m_v[13];
    assign m_43 = m_v[14];
    assign m_44 = m_v[15];

endmodule

// File: tb/tb_one_unit_mean_accumulator.sv
// Directed and randomized checks of the mean accumulator at N_LOG2=2
// against an arithmetic mean model.
module tb_one_unit_mean_accumulator;

    localparam int DW     = 26;
    localparam int N_LOG2 = 2;
    localparam int N      = 1 << N_LOG2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic busy;
    logic done;

    logic signed [DW-1:0] in_arr [16];
    logic signed [DW-1:0] m_arr  [16];
    logic signed [DW-1:0] smp    [N][16];
    logic signed [DW-1:0] exp_m  [16];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    one_unit_mean_accumulator #(
        .DW     (DW),
        .N_LOG2 (N_LOG2)
    ) dut (
        .clk_mean (clk),
        .rst_mean (rst),
        .start    (start),
        .in_valid (in_valid),
        .i_11 (in_arr[0]),  .i_12 (in_arr[1]),
        .i_13 (in_arr[2]),  .i_14 (in_arr[3]),
        .i_21 (in_arr[4]),  .i_22 (in_arr[5]),
        .i_23 (in_arr[6]),  .i_24 (in_arr[7]),
        .i_31 (in_arr[8]),  .i_32 (in_arr[9]),
        .i_33 (in_arr[10]), .i_34 (in_arr[11]),
        .i_41 (in_arr[12]), .i_42 (in_arr[13]),
        .i_43 (in_arr[14]), .i_44 (in_arr[15]),
        .m_11 (m_arr[0]),   .m_12 (m_arr[1]),
        .m_13 (m_arr[2]),   .m_14 (m_arr[3]),
        .m_21 (m_arr[4]),   .m_22 (m_arr[5]),
        .m_23 (m_arr[6]),   .m_24 (m_arr[7]),
        .m_31 (m_arr[8]),   .m_32 (m_arr[9]),
        .m_33 (m_arr[10]),  .m_34 (m_arr[11]),
        .m_41 (m_arr[12]),  .m_42 (m_arr[13]),
        .m_43 (m_arr[14]),  .m_44 (m_arr[15]),
        .busy (busy),
        .done (done)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, req);
        end
    endtask

    task automatic chk_val(input string tag, input int lane,
                           input logic signed [DW-1:0] obs,
                           input logic signed [DW-1:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s lane=%0d observed=%0d expected=%0d",
                   tag, lane, obs, req);
        end
    endtask

    // Mean of the accepted samples: exact integer sum, floored divide by N
    task automatic model_mean();
        for (int l = 0; l < 16; l++) begin
            longint sum = 0;
            longint q;
            for (int k = 0; k < N; k++) sum += longint'(smp[k][l]);
            q = sum / N;
            if ((sum % N != 0) && (sum < 0)) q = q - 1;
            exp_m[l] = DW'(q);
        end
    endtask

    task automatic rand_inputs();
        for (int l = 0; l < 16; l++) in_arr[l] = DW'($urandom);
    endtask

    task automatic check_means(input string tag);
        for (int l = 0; l < 16; l++) chk_val(tag, l, m_arr[l], exp_m[l]);
    endtask

    // Called one negedge after the edge that accepted the Nth sample
    task automatic tail(input string tag);
        in_valid = 1'b0;
        start = 1'b0;
        rand_inputs();
        chk_bit({tag, "_done_early"}, done, 1'b0);
        chk_bit({tag, "_busy_in_done"}, busy, 1'b1);
        model_mean();
        @(negedge clk);
        chk_bit({tag, "_done_pulse"}, done, 1'b1);
        chk_bit({tag, "_busy_low"}, busy, 1'b0);
        check_means(tag);
        @(negedge clk);
        chk_bit({tag, "_done_once"}, done, 1'b0);
        @(negedge clk);
        check_means({tag, "_hold"});
    endtask

    task automatic run(input string tag, input bit collide,
                       input bit gapped, input bit start_mid);
        start = 1'b1;
        in_valid = collide;
        rand_inputs();
        @(negedge clk);
        start = 1'b0;
        chk_bit({tag, "_busy_acc"}, busy, 1'b1);
        for (int k = 0; k < N; k++) begin
            if (gapped && k > 0) begin
                in_valid = 1'b0;
                rand_inputs();
                @(negedge clk);
                chk_bit({tag, "_gap_no_done"}, done, 1'b0);
            end
            in_valid = 1'b1;
            start = start_mid && (k == 2);
            for (int l = 0; l < 16; l++) in_arr[l] = smp[k][l];
            @(negedge clk);
        end
        tail(tag);
    endtask

    task automatic fill(input logic signed [DW-1:0] v0,
                        input logic signed [DW-1:0] v1,
                        input logic signed [DW-1:0] v2,
                        input logic signed [DW-1:0] v3);
        for (int l = 0; l < 16; l++) begin
            smp[0][l] = v0;
            smp[1][l] = v1;
            smp[2][l] = v2;
            smp[3][l] = v3;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < N; k++)
            for (int l = 0; l < 16; l++) smp[k][l] = DW'($urandom);
    endtask

    initial begin
        int acc;
        int budget;
        bit v;
        for (int l = 0; l < 16; l++) in_arr[l] = '0;
        rst = 1'b1;
        #12;
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_done", done, 1'b0);
        for (int l = 0; l < 16; l++) exp_m[l] = '0;
        check_means("reset_m");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // in_valid is ignored while idle
        in_valid = 1'b1;
        rand_inputs();
        @(negedge clk);
        chk_bit("idle_valid_busy", busy, 1'b0);

        fill(26'sd10, 26'sd20, 26'sd30, 26'sd40);
        run("basic", 1'b0, 1'b0, 1'b0);

        fill_rand();
        smp[0][0] = -26'sd1;
        smp[1][0] = -26'sd2;
        smp[2][0] = -26'sd3;
        smp[3][0] = -26'sd3;
        smp[0][1] = 26'sd5;
        smp[1][1] = 26'sd0;
        smp[2][1] = 26'sd0;
        smp[3][1] = 26'sd0;
        run("neg_floor", 1'b0, 1'b0, 1'b0);
        chk_val("neg_floor_m11", 0, m_arr[0], -26'sd3);
        chk_val("neg_floor_m12", 1, m_arr[1], 26'sd1);

        fill(26'sd8, 26'sd8, 26'sd8, 26'sd8);
        run("gapped", 1'b0, 1'b1, 1'b0);

        fill(26'h1FFFFFF, 26'h1FFFFFF, 26'h1FFFFFF, 26'h1FFFFFF);
        run("full_pos", 1'b0, 1'b0, 1'b0);
        fill(26'h2000000, 26'h2000000, 26'h2000000, 26'h2000000);
        run("full_neg", 1'b0, 1'b0, 1'b0);

        fill_rand();
        run("start_mid", 1'b0, 1'b0, 1'b1);

        fill_rand();
        run("collide", 1'b1, 1'b0, 1'b0);

        // Randomized valid/start traffic
        for (int r = 0; r < 6; r++) begin
            fill_rand();
            start = 1'b1;
            in_valid = 1'($urandom);
            rand_inputs();
            @(negedge clk);
            acc = 0;
            budget = 0;
            while (acc < N && budget < 64) begin
                v = 1'($urandom);
                start = 1'($urandom);
                in_valid = v;
                if (v) begin
                    for (int l = 0; l < 16; l++) in_arr[l] = smp[acc][l];
                end else begin
                    rand_inputs();
                end
                @(negedge clk);
                if (v) acc++;
                budget++;
                if (acc < N) chk_bit("rand_busy", busy, 1'b1);
            end
            chk_bit("rand_budget", acc == N, 1'b1);
            tail($sformatf("rand%0d", r));
        end

        // Abort mid-run with reset
        fill_rand();
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            for (int l = 0; l < 16; l++) in_arr[l] = smp[k][l];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_bit("abort_busy", busy, 1'b0);
        chk_bit("abort_done", done, 1'b0);
        for (int l = 0; l < 16; l++) exp_m[l] = '0;
        check_means("abort_m");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_bit("abort_no_done", done, 1'b0);
        @(negedge clk);
        fill(26'sd7, 26'sd7, 26'sd7, 26'sd7);
        run("after_abort", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/one_unit_mean_accumulator.md
ONE_UNIT_MEAN_ACCUMULATOR -- requirements
Module: one_unit_mean_accumulator

Interface
REQ-001 SHALL have parameter DW, default 26, data width of every sample and mean element.
REQ-002 SHALL have parameter N_LOG2, default 8, log2 of samples per mean (N = 2^N_LOG2).
REQ-003 SHALL have port clk_mean  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_mean  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins a new N-sample accumulation when idle.
REQ-006 SHALL have port in_valid  input  1  current sample i_11..i_44 is valid.
REQ-007 SHALL have ports i_11..i_44  input  16 x DW signed  per-sample 4x4 term x*(w'x)^3.
REQ-008 SHALL have ports m_11..m_44  output  16 x DW signed registered  mean matrix; drives the subtractor mean inputs.
REQ-009 SHALL have port busy  output  1  high in ACC and DONE states.
REQ-010 SHALL have port done  output  1  one-cycle pulse; m_xx updated this cycle; drives subtractor enable.

Function
REQ-011 SHALL implement states IDLE, ACC and DONE; reset state IDLE.
REQ-012 In IDLE with start=1, SHALL clear all 16 accumulators and the sample counter, then enter ACC.
REQ-013 In ACC, each cycle with in_valid=1 SHALL add each sign-extended i_rc to accumulator rc and increment the counter.
REQ-014 In ACC, cycles with in_valid=0 SHALL leave accumulators and counter unchanged.
REQ-015 Accumulators SHALL be DW+N_LOG2 bits signed; no overflow is possible for N samples.
REQ-016 Counter SHALL be N_LOG2 bits; the edge accepting the sample with counter = N-1 SHALL move the FSM to DONE.
REQ-017 The edge leaving DONE SHALL load m_rc with acc_rc arithmetically shifted right by N_LOG2, truncated to DW bits, rounding toward minus infinity.
REQ-018 The same edge SHALL set done=1 for exactly one cycle and return the FSM to IDLE.
REQ-019 done SHALL first be high 2 cycles after the cycle presenting the Nth valid sample.
REQ-020 m_rc SHALL hold its value between done pulses.
REQ-021 start SHALL be ignored in ACC and DONE.
REQ-022 in_valid SHALL be ignored in IDLE and DONE.
REQ-023 When start and in_valid are both high in IDLE, that sample SHALL NOT be accumulated.
REQ-024 busy SHALL be combinational from state.
REQ-025 done SHALL be a register.

Reset
REQ-026 rst_mean high SHALL asynchronously force state IDLE, counter 0, all accumulators 0, m_rc 0, done 0 and busy 0.
REQ-027 Reset during ACC or DONE SHALL abort the accumulation with no done pulse.
REQ-028 The next start after reset SHALL begin a fresh accumulation.

Structure
REQ-029 A shared package SHALL hold DW, the default N_LOG2 and the state encoding (IDLE, ACC, DONE).
REQ-030 The subtractor SHALL use the same DW from that package.
REQ-031 One sub-module, one_unit_mean_lane, SHALL hold one accumulator, add and shift.
REQ-032 one_unit_mean_lane SHALL be instantiated 16 times.
REQ-033 The FSM and counter SHALL be shared by all lanes.

Verification (N_LOG2=2)
REQ-034 Basic mean: start, then 4 valid samples with every i_rc = 10, 20, 30, 40 -> done 2 cycles after the 4th sample, all m_rc = 25, busy low next cycle.
REQ-035 Negative floor: i_11 = -1, -2, -3, -3 (sum -9) -> m_11 = -3; i_12 = 5, 0, 0, 0 -> m_12 = 1.
REQ-036 Gapped valid: 4 valid samples of value 8 interleaved with 3 in_valid=0 cycles -> m_rc = 8; done only after the 4th valid sample.
REQ-037 Full range: all samples 2^25-1 -> m = 2^25-1; all samples -2^25 -> m = -2^25; no wrap.
REQ-038 Ignored start: start pulsed during ACC after 2 samples -> result unaffected.
REQ-039 Start collision: start with in_valid=1 in IDLE -> that sample excluded from the result.
REQ-040 Reset abort: rst_mean asserted after 3 samples -> m = 0, no done; a new 4-sample run of 7 -> m_rc = 7.
